// File: rtl/guess_match_checker_if.sv
// guess_match_checker_if: round control, guess/target operands and result outputs
//   master: drives start, sw, number; observes compare flags, armed, match, attempts
//   slave : the checker side of the same signals
interface guess_match_checker_if #(
  parameter int WIDTH = 8,
  parameter int ATT_W = 8
);
  logic             start;
  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] number;
  logic             is_equal;
  logic             is_greater;
  logic             is_less;
  logic             armed;
  logic             match;
  logic [ATT_W-1:0] attempts;
  modport master (
    output start, sw, number,
    input  is_equal, is_greater, is_less, armed, match, attempts
  );
  modport slave (
    input  start, sw, number,
    output is_equal, is_greater, is_less, armed, match, attempts
  );
endinterface

// File: rtl/guess_match_checker.sv
// guess_match_checker: declares a match once sw has equalled number for HOLD_CYCLES consecutive edges
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of guess_match_checker_if (start, sw, number in;
//          is_equal/is_greater/is_less, armed, match, attempts out)
module guess_match_checker #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int ATT_W       = 8
) (
  input logic                   clk,
  input logic                   rst,
  guess_match_checker_if.slave  bus
);
  // one spare count so the increment on the final equal edge cannot wrap
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
  state_t           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [ATT_W-1:0] att_q, att_d;
  logic [WIDTH-1:0] sw_q;
  logic             eq_q, gt_q, lt_q;
  logic             eq;
  assign eq = bus.sw == bus.number;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      att_q   <= '0;
      sw_q    <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      att_q   <= att_d;
      sw_q    <= bus.sw;
      eq_q    <= eq;
      gt_q    <= bus.sw > bus.number;
      lt_q    <= bus.sw < bus.number;
    end
  end
  // start restarts the round from any state and overrides counting and the DONE transition
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    att_d   = att_q;
    if (bus.start) begin
      state_d = ARMED;
      hold_d  = '0;
      att_d   = '0;
    end else if (state_q == ARMED) begin
      hold_d  = eq ? hold_q + 1'b1 : '0;
      att_d   = (bus.sw != sw_q && att_q != '1) ? att_q + 1'b1 : att_q;
      state_d = (eq && hold_q == HW'(HOLD_CYCLES - 1)) ? DONE : ARMED;
    end
  end
  assign bus.is_equal   = eq_q;
  assign bus.is_greater = gt_q;
  assign bus.is_less    = lt_q;
  assign bus.armed      = state_q == ARMED;
  assign bus.match      = state_q == DONE;
  assign bus.attempts   = att_q;
endmodule
